vx_vector_beat_sequencer: RTL and testbench

Parametrised vector-operand sequencer between the vector register read stage and the per-lane ALU.
- Accepts one vs1/vs2 vector register pair with its vl and SEW per request.
- Splits the elements into NUM_LANES-wide beats, one element per lane, zero-extended to XLEN.
- Emits the beats over a valid/ready handshake with a per-lane active mask and a last-beat flag.
- Generalises the fixed 2-beat unroll to any VLEN/NUM_LANES/SEW combination, with vl-based masking and full backpressure.

---
 rtl/vx_vector_beat_sequencer.sv | 174 +++++++++++++++++
 tb/tb_vx_vector_beat_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_vector_beat_sequencer.sv
// vx_vector_beat_sequencer
// Splits one vs1/vs2 vector register pair into NUM_LANES-wide beats, one
// element per lane, zero-extended to XLEN, with a vl-based lane mask and a
// last-beat flag, over valid/ready handshakes on both sides.
// Optional feature macro: VX_VEC_SEQ_B2B_EN -- when defined, a new request
// may be accepted in the same cycle as the last beat handshake (no bubble).

`ifndef VLEN_ARCH
`define VLEN_ARCH 256
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

module vx_vector_beat_sequencer #(
    parameter int VLEN      = `VLEN_ARCH,
    parameter int NUM_LANES = `NUM_THREADS,
    parameter int TAG_WIDTH = 8,
    parameter int XLEN      = 32,
    localparam int VL_W     = $clog2(VLEN / 8) + 1,
    localparam int BEAT_W   = $clog2(VLEN / 8 / NUM_LANES) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [VLEN-1:0]           vs1_data_in,
    input  logic [VLEN-1:0]           vs2_data_in,
    input  logic [VL_W-1:0]           vl_in,
    input  logic [1:0]                sew_in,
    input  logic [TAG_WIDTH-1:0]      tag_in,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [NUM_LANES*XLEN-1:0] vs1_data_out,
    output logic [NUM_LANES*XLEN-1:0] vs2_data_out,
    output logic [NUM_LANES-1:0]      lane_mask_out,
    output logic [BEAT_W-1:0]         beat_idx_out,
    output logic                      last_out,
    output logic [TAG_WIDTH-1:0]      tag_out,
    output logic                      busy
);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t state;

    logic [VLEN-1:0] vs1_q;
    logic [VLEN-1:0] vs2_q;
    logic [VL_W-1:0] vl_q;
    logic [1:0]      sew_q;

    logic [1:0]      sew_eff_in;
    logic [VL_W-1:0] vlmax_in;
    logic [VL_W-1:0] vl_eff_in;
    logic            hs;
    logic            accept;
    logic            load;
    logic            advance;

    logic [VLEN-1:0]           src1;
    logic [VLEN-1:0]           src2;
    logic [VL_W-1:0]           src_vl;
    logic [1:0]                src_sew;
    logic [BEAT_W-1:0]         nxt_beat;
    logic [XLEN-1:0]           elem_mask;
    logic [31:0]               elem;
    logic [31:0]               shamt;
    logic [VLEN-1:0]           sh1;
    logic [VLEN-1:0]           sh2;
    logic [NUM_LANES*XLEN-1:0] nxt_vs1;
    logic [NUM_LANES*XLEN-1:0] nxt_vs2;
    logic [NUM_LANES-1:0]      nxt_mask;
    logic                      nxt_last;

    // SEW64 collapses to SEW32 when the lanes are only 32 bits wide
    assign sew_eff_in = (XLEN < 64 && sew_in == 2'b11) ? 2'b10 : sew_in;
    assign vlmax_in   = VL_W'(VLEN / 8) >> sew_eff_in;
    assign vl_eff_in  = (vl_in > vlmax_in) ? vlmax_in : vl_in;

    assign hs     = valid_out && ready_out;
`ifdef VX_VEC_SEQ_B2B_EN
    assign ready_in = (state == IDLE) || (hs && last_out);
`else
    assign ready_in = (state == IDLE);
`endif
    assign accept  = valid_in && ready_in;
    assign load    = accept && (vl_eff_in != '0);
    assign advance = load || (hs && !last_out);
    assign busy    = (state == ISSUE);

    // Pick the source of the next beat (fresh request or captured one) and slice lanes
    always_comb begin
        if (load) begin
            src1     = vs1_data_in;
            src2     = vs2_data_in;
            src_vl   = vl_eff_in;
            src_sew  = sew_eff_in;
            nxt_beat = '0;
        end else begin
            src1     = vs1_q;
            src2     = vs2_q;
            src_vl   = vl_q;
            src_sew  = sew_q;
            nxt_beat = beat_idx_out + BEAT_W'(1);
        end
        // a shift by the full lane width yields 0, so the mask becomes all ones
        elem_mask = ~({XLEN{1'b1}} << (32'd8 << src_sew));
        elem      = '0;
        shamt     = '0;
        sh1       = '0;
        sh2       = '0;
        nxt_vs1   = '0;
        nxt_vs2   = '0;
        nxt_mask  = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            elem  = 32'(nxt_beat) * 32'(NUM_LANES) + 32'(l);
            shamt = elem << (32'd3 + 32'(src_sew));
            sh1   = src1 >> shamt;
            sh2   = src2 >> shamt;
            if (elem < 32'(src_vl)) begin
                nxt_mask[l]             = 1'b1;
                nxt_vs1[l*XLEN +: XLEN] = sh1[XLEN-1:0] & elem_mask;
                nxt_vs2[l*XLEN +: XLEN] = sh2[XLEN-1:0] & elem_mask;
            end
        end
        nxt_last = ((32'(nxt_beat) + 32'd1) * 32'(NUM_LANES)) >= 32'(src_vl);
    end

    // Request capture, registered beat presentation and IDLE/ISSUE sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            vs1_q         <= '0;
            vs2_q         <= '0;
            vl_q          <= '0;
            sew_q         <= '0;
            valid_out     <= 1'b0;
            vs1_data_out  <= '0;
            vs2_data_out  <= '0;
            lane_mask_out <= '0;
            beat_idx_out  <= '0;
            last_out      <= 1'b0;
            tag_out       <= '0;
        end else begin
            if (load) begin
                vs1_q   <= vs1_data_in;
                vs2_q   <= vs2_data_in;
                vl_q    <= vl_eff_in;
                sew_q   <= sew_eff_in;
                tag_out <= tag_in;
            end
            // load from IDLE, next beat, and same-cycle reload after the last
            // beat all share one presentation path; load has priority
            if (advance) begin
                state         <= ISSUE;
                valid_out     <= 1'b1;
                vs1_data_out  <= nxt_vs1;
                vs2_data_out  <= nxt_vs2;
                lane_mask_out <= nxt_mask;
                beat_idx_out  <= nxt_beat;
                last_out      <= nxt_last;
            end else if (hs) begin
                state         <= IDLE;
                valid_out     <= 1'b0;
                last_out      <= 1'b0;
                lane_mask_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vx_vector_beat_sequencer.sv
// Testbench for vx_vector_beat_sequencer: directed requests checked against a
// queue of expected beats built from element arithmetic, plus literal checks.
`timescale 1ns/1ps
module tb_vx_vector_beat_sequencer;
    localparam int VLEN   = 256;
    localparam int NL     = 4;
    localparam int XLEN   = 32;
    localparam int TW     = 8;
    localparam int VL_W   = 6;
    localparam int BEAT_W = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 valid_in = 1'b0;
    logic                 ready_in;
    logic [VLEN-1:0]      vs1_data_in = '0;
    logic [VLEN-1:0]      vs2_data_in = '0;
    logic [VL_W-1:0]      vl_in = '0;
    logic [1:0]           sew_in = '0;
    logic [TW-1:0]        tag_in = '0;
    logic                 valid_out;
    logic                 ready_out = 1'b1;
    logic [NL*XLEN-1:0]   vs1_data_out;
    logic [NL*XLEN-1:0]   vs2_data_out;
    logic [NL-1:0]        lane_mask_out;
    logic [BEAT_W-1:0]    beat_idx_out;
    logic                 last_out;
    logic [TW-1:0]        tag_out;
    logic                 busy;

    vx_vector_beat_sequencer #(
        .VLEN(VLEN), .NUM_LANES(NL), .TAG_WIDTH(TW), .XLEN(XLEN)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .vs1_data_in(vs1_data_in), .vs2_data_in(vs2_data_in), .vl_in(vl_in),
        .sew_in(sew_in), .tag_in(tag_in), .valid_out(valid_out), .ready_out(ready_out),
        .vs1_data_out(vs1_data_out), .vs2_data_out(vs2_data_out),
        .lane_mask_out(lane_mask_out), .beat_idx_out(beat_idx_out),
        .last_out(last_out), .tag_out(tag_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL*XLEN-1:0] d1;
        logic [NL*XLEN-1:0] d2;
        logic [NL-1:0]      mask;
        logic [BEAT_W-1:0]  idx;
        logic               last;
        logic [TW-1:0]      tag;
        int unsigned        cyc;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_vle(input int vl, input int sew);
        int code  = (sew == 3 && XLEN == 32) ? 2 : sew;
        int vlmax = VLEN / (8 << code);
        return (vl < vlmax) ? vl : vlmax;
    endfunction

    // Expected beats: element e of width w bytes lives at bytes [e*w, e*w+w)
    task automatic model_push(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                              input int vl, input int sew, input logic [TW-1:0] tag);
        int code  = (sew == 3 && XLEN == 32) ? 2 : sew;
        int bytes = 1 << code;
        int vle   = model_vle(vl, sew);
        int nb    = (vle + NL - 1) / NL;
        for (int bi = 0; bi < nb; bi++) begin
            beat_t t;
            t = '0;
            for (int ln = 0; ln < NL; ln++) begin
                int e = bi * NL + ln;
                if (e < vle) begin
                    t.mask[ln] = 1'b1;
                    for (int k = 0; k < bytes; k++) begin
                        t.d1[ln*XLEN + 8*k +: 8] = a[(e*bytes + k)*8 +: 8];
                        t.d2[ln*XLEN + 8*k +: 8] = b[(e*bytes + k)*8 +: 8];
                    end
                end
            end
            t.idx  = BEAT_W'(bi);
            t.last = (bi == nb - 1);
            t.tag  = tag;
            exp_q.push_back(t);
        end
    endtask

    function automatic beat_t obs_at(input int i);
        beat_t z;
        z = '0;
        if (i < obs_q.size()) z = obs_q[i];
        return z;
    endfunction

    // Compare every presented beat against the head of the expected queue
    always @(negedge clk) begin : compare
        beat_t e;
        beat_t o;
        if (reset) begin
            exp_q.delete();
        end else if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", valid_out, 1'b0);
            end else begin
                e = exp_q[0];
                check("beat_vs1", vs1_data_out, e.d1);
                check("beat_vs2", vs2_data_out, e.d2);
                check("beat_ctrl{tag,idx,last,mask}",
                      {tag_out, beat_idx_out, last_out, lane_mask_out},
                      {e.tag, e.idx, e.last, e.mask});
                if (ready_out) begin
                    o.d1 = vs1_data_out; o.d2 = vs2_data_out; o.mask = lane_mask_out;
                    o.idx = beat_idx_out; o.last = last_out; o.tag = tag_out; o.cyc = cyc;
                    obs_q.push_back(o);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge
    task automatic send(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                        input int vl, input int sew, input logic [TW-1:0] tag);
        int n = 0;
        vs1_data_in = a; vs2_data_in = b; vl_in = VL_W'(vl); sew_in = 2'(sew);
        tag_in = tag; valid_in = 1'b1;
        @(negedge clk);
        while (!ready_in && n < 50) begin n++; @(negedge clk); end
        check("accept_timeout", ready_in, 1'b1);
        if (!ready_in) begin
            valid_in = 1'b0;
            return;
        end
        model_push(a, b, vl, sew, tag);
        @(posedge clk); #1;
        valid_in = 1'b0;
        vs1_data_in = {8{$urandom}}; vs2_data_in = {8{$urandom}};
        vl_in = VL_W'($urandom); tag_in = TW'($urandom);
        @(negedge clk);
        check("first_beat_latency", valid_out, model_vle(vl, sew) != 0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        check("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    logic [VLEN-1:0] va, vb, vbyte;

    initial begin
        for (int i = 0; i < 8; i++) begin
            va[i*32 +: 32] = 32'hA000_0000 + i;
            vb[i*32 +: 32] = 32'hB000_0000 + i;
        end
        for (int k = 0; k < 32; k++) vbyte[k*8 +: 8] = 8'(k + 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid_out", valid_out, 1'b0);
        check("reset_ready_in", ready_in, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_ctrl", {last_out, lane_mask_out, beat_idx_out, tag_out}, 0);
        check("reset_data", {vs1_data_out, vs2_data_out}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // SEW32, vl=8: two full beats
        obs_q.delete();
        send(va, vb, 8, 2, 8'h01); drain();
        check("t1_nbeats", obs_q.size(), 2);
        check("t1_mask0", obs_at(0).mask, 4'hF);
        check("t1_mask1", obs_at(1).mask, 4'hF);
        check("t1_last0", obs_at(0).last, 1'b0);
        check("t1_last1", obs_at(1).last, 1'b1);
        check("t1_b1_vs1_lane0", obs_at(1).d1[31:0], 32'hA000_0004);
        check("t1_b1_vs2_lane3", obs_at(1).d2[127:96], 32'hB000_0007);

        // SEW32, vl=5: partial second beat
        obs_q.delete();
        send(va, vb, 5, 2, 8'h02); drain();
        check("t2_nbeats", obs_q.size(), 2);
        check("t2_mask1", obs_at(1).mask, 4'b0001);
        check("t2_inactive_vs1", obs_at(1).d1[127:32], 0);
        check("t2_inactive_vs2", obs_at(1).d2[127:32], 0);
        check("t2_b1_lane0", obs_at(1).d1[31:0], 32'hA000_0004);

        // vl=20 clamps to VLMAX=8
        obs_q.delete();
        send(va, vb, 20, 2, 8'h03); drain();
        check("t3_nbeats", obs_q.size(), 2);
        check("t3_last1", obs_at(1).last, 1'b1);

        // SEW8, vl=10, byte k = k+1
        obs_q.delete();
        send(vbyte, vb, 10, 0, 8'h04); drain();
        check("t4_nbeats", obs_q.size(), 3);
        check("t4_mask2", obs_at(2).mask, 4'b0011);
        check("t4_b2_lane1", obs_at(2).d1[63:32], 32'h0000_000A);
        check("t4_b2_lane0", obs_at(2).d1[31:0], 32'h0000_0009);
        check("t4_b2_inactive", obs_at(2).d1[127:64], 0);

        // SEW64 on 32-bit lanes acts as SEW32
        obs_q.delete();
        send(va, vb, 8, 3, 8'h05); drain();
        check("t5_nbeats", obs_q.size(), 2);
        check("t5_b1_lane0", obs_at(1).d1[31:0], 32'hA000_0004);

        // SEW16, vl=16: four beats
        obs_q.delete();
        send(va, vb, 16, 1, 8'h06); drain();
        check("t6_nbeats", obs_q.size(), 4);
        check("t6_b3_lane3", obs_at(3).d1[127:96], 32'h0000_A000);
        check("t6_b3_lane2", obs_at(3).d1[95:64], 32'h0000_0007);

        // Backpressure: hold beat 0 for three cycles
        obs_q.delete();
        ready_out = 1'b0;
        send(va, vb, 8, 2, 8'h07);
        repeat (2) begin
            @(negedge clk);
            check("stall_valid", valid_out, 1'b1);
            check("stall_ready_in", ready_in, 1'b0);
            check("stall_busy", busy, 1'b1);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        drain();
        check("stall_nbeats", obs_q.size(), 2);
        check("stall_b1_follows", obs_at(1).cyc - obs_at(0).cyc, 1);

        // vl=0 emits nothing
        obs_q.delete();
        send(va, vb, 0, 2, 8'h08);
        repeat (3) begin
            @(negedge clk);
            check("vl0_ready_in", ready_in, 1'b1);
            check("vl0_busy", busy, 1'b0);
            check("vl0_valid", valid_out, 1'b0);
        end
        @(posedge clk); #1;
        check("vl0_nbeats", obs_q.size(), 0);

        // Reset during beat 1 of 3 drops the request
        obs_q.delete();
        send(vbyte, vb, 10, 0, 8'h09);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_valid", valid_out, 1'b0);
        check("rst_mid_ready_in", ready_in, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_mid_quiet", valid_out, 1'b0);
        end
        @(posedge clk); #1;
        check("rst_mid_nbeats", obs_q.size(), 1);

        // Back-to-back requests
        obs_q.delete();
        send(va, vb, 8, 2, 8'h11);
        send(vb, va, 8, 2, 8'h22);
        drain();
        check("b2b_nbeats", obs_q.size(), 4);
        check("b2b_first_last_tag", {obs_at(1).tag, obs_at(1).last}, {8'h11, 1'b1});
        check("b2b_second_tag", {obs_at(2).tag, obs_at(2).idx}, {8'h22, 4'd0});
`ifdef VX_VEC_SEQ_B2B_EN
        check("b2b_gap", obs_at(2).cyc - obs_at(1).cyc, 1);
`else
        check("b2b_gap", obs_at(2).cyc - obs_at(1).cyc, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
